sg_elem_requester: RTL and testbench



---
 rtl/sg_elem_requester_if.sv | 19 +
 rtl/sg_elem_requester.sv | 92 +++++++++
 tb/tb_sg_elem_requester.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/sg_elem_requester_if.sv
// sg_elem_requester_if: SG element pop and upstream read request handshakes.
interface sg_elem_requester_if;
  logic        ELEM_VALID;
  logic        ELEM_REN;
  logic [63:0] ELEM_ADDR;
  logic [31:0] ELEM_LEN;
  logic        REQ;
  logic        REQ_ACK;
  logic [63:0] REQ_ADDR;
  logic [9:0]  REQ_LEN;
  modport master (
    input  ELEM_VALID, ELEM_ADDR, ELEM_LEN, REQ_ACK,
    output ELEM_REN, REQ, REQ_ADDR, REQ_LEN
  );
  modport slave (
    output ELEM_VALID, ELEM_ADDR, ELEM_LEN, REQ_ACK,
    input  ELEM_REN, REQ, REQ_ADDR, REQ_LEN
  );
endinterface

// File: rtl/sg_elem_requester.sv
// sg_elem_requester: splits SG elements into max-size, 4KB-bounded read requests gated on receive buffer room.
module sg_elem_requester #(
  parameter int C_DATA_WIDTH = 128,
  parameter int C_FIFO_WORDS = 4096,
  parameter int C_MAX_READ_REQ = 2,
  localparam int C_DATA_WORD_WIDTH = $clog2((C_DATA_WIDTH / 32) + 1),
  localparam int OW = $clog2(C_FIFO_WORDS) + 1
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [2:0]                   CONFIG_MAX_READ_REQUEST_SIZE,
  sg_elem_requester_if.master          bus,
  input  logic [C_DATA_WORD_WIDTH-1:0] CONSUMED_WORDS,
  input  logic                         ABORT,
  output logic                         ELEM_DONE,
  output logic                         BUSY
);
  typedef enum logic [1:0] {IDLE, CALC, ISSUE} state_t;
  localparam logic [2:0] CAP = C_MAX_READ_REQ > 5 ? 3'd5 : 3'(C_MAX_READ_REQ);
  state_t r_state, w_state_n;
  logic [63:0] r_addr;
  logic [31:0] r_remain;
  logic [10:0] r_len, w_mx, w_bnd, w_lim, w_len;
  logic [OW-1:0] r_outstanding, w_out_n;
  logic [OW:0] w_sum, w_cons;
  logic [2:0] w_cfg;
  logic r_done, w_done_n, w_pop, w_ack, w_fit, w_last;
  assign w_pop = r_state == IDLE && bus.ELEM_VALID && !ABORT;
  assign w_ack = r_state == ISSUE && bus.REQ_ACK;
  assign w_last = r_remain == {21'd0, r_len};
  assign bus.ELEM_REN = w_pop;
  assign bus.REQ = r_state == ISSUE;
  assign bus.REQ_ADDR = r_addr;
  assign bus.REQ_LEN = r_len[9:0];
  assign ELEM_DONE = r_done;
  assign BUSY = r_state != IDLE;
  // Request length: min of remaining words, size cap and words left in the 4KB page.
  assign w_cfg = CONFIG_MAX_READ_REQUEST_SIZE < CAP ? CONFIG_MAX_READ_REQUEST_SIZE : CAP;
  assign w_mx = 11'd32 << w_cfg;
  assign w_bnd = 11'd1024 - {1'b0, r_addr[11:2]};
  assign w_lim = w_mx < w_bnd ? w_mx : w_bnd;
  assign w_len = r_remain < {21'd0, w_lim} ? r_remain[10:0] : w_lim;
  assign w_fit = 32'(r_outstanding) + 32'(w_len) <= 32'(C_FIFO_WORDS);
  // Outstanding words: net of accepted request and drained words, floored at zero.
  assign w_sum = {1'b0, r_outstanding} + (w_ack ? (OW+1)'(r_len) : '0);
  assign w_cons = (OW+1)'(CONSUMED_WORDS);
  assign w_out_n = w_sum > w_cons ? OW'(w_sum - w_cons) : '0;
  always_comb begin
    w_state_n = r_state;
    w_done_n = 1'b0;
    case (r_state)
      IDLE: if (w_pop) begin
        if (bus.ELEM_LEN != 0) w_state_n = CALC;
        w_done_n = bus.ELEM_LEN == 0;
      end
      CALC: if (w_fit) w_state_n = ISSUE;
      ISSUE: if (w_ack) begin
        w_state_n = w_last ? IDLE : CALC;
        w_done_n = w_last;
      end
      default: w_state_n = IDLE;
    endcase
    if (ABORT) begin
      w_state_n = IDLE;
      w_done_n = 1'b0;
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) r_state <= IDLE;
    else r_state <= w_state_n;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_done <= 1'b0;
      r_addr <= '0;
      r_remain <= '0;
      r_len <= '0;
      r_outstanding <= '0;
    end else begin
      r_done <= w_done_n;
      r_outstanding <= w_out_n;
      if (w_pop) begin
        r_addr <= bus.ELEM_ADDR & ~64'h3;
        r_remain <= bus.ELEM_LEN;
      end else if (w_ack) begin
        r_addr <= r_addr + {51'd0, r_len, 2'b00};
        r_remain <= r_remain - {21'd0, r_len};
      end
      if (r_state == CALC) r_len <= w_len;
    end
  end
endmodule

// File: tb/tb_sg_elem_requester.sv
// tb_sg_elem_requester: directed and random checks of request splitting, space gating, abort and done timing.
module tb_sg_elem_requester;
  typedef struct packed {logic [63:0] a; logic [9:0] l;} req_t;
  logic clk = 1'b0, rst = 1'b1, ev = 1'b0, ack = 1'b0, abort = 1'b0, rnd_en = 1'b0, inv_en = 1'b0;
  logic [2:0] cfg = 3'd0, cons = 3'd0;
  logic [63:0] ea = '0, sum_req = '0, sum_elem = '0;
  logic [31:0] el = '0;
  int sel = 0, pass_n = 0, total = 0;
  req_t sbq[$];
  logic done_a, done_b, done_c, busy_a, busy_b, busy_c;
  logic o_req, o_ren, o_done, o_busy;
  logic [63:0] o_addr;
  logic [9:0] o_len;
  int o_out;
  always #5 clk = ~clk;
  sg_elem_requester_if ia(), ib(), ic();
  assign ia.ELEM_VALID = ev;
  assign ib.ELEM_VALID = ev;
  assign ic.ELEM_VALID = ev;
  assign ia.ELEM_ADDR = ea;
  assign ib.ELEM_ADDR = ea;
  assign ic.ELEM_ADDR = ea;
  assign ia.ELEM_LEN = el;
  assign ib.ELEM_LEN = el;
  assign ic.ELEM_LEN = el;
  assign ia.REQ_ACK = ack;
  assign ib.REQ_ACK = ack;
  assign ic.REQ_ACK = ack;
  sg_elem_requester #(.C_MAX_READ_REQ(2)) da (.CLK(clk), .RST(rst), .CONFIG_MAX_READ_REQUEST_SIZE(cfg), .bus(ia),
    .CONSUMED_WORDS(cons), .ABORT(abort), .ELEM_DONE(done_a), .BUSY(busy_a));
  sg_elem_requester #(.C_MAX_READ_REQ(5)) db (.CLK(clk), .RST(rst), .CONFIG_MAX_READ_REQUEST_SIZE(cfg), .bus(ib),
    .CONSUMED_WORDS(cons), .ABORT(abort), .ELEM_DONE(done_b), .BUSY(busy_b));
  sg_elem_requester #(.C_MAX_READ_REQ(2), .C_FIFO_WORDS(64)) dc (.CLK(clk), .RST(rst), .CONFIG_MAX_READ_REQUEST_SIZE(cfg), .bus(ic),
    .CONSUMED_WORDS(cons), .ABORT(abort), .ELEM_DONE(done_c), .BUSY(busy_c));
  always_comb begin
    o_req = sel == 0 ? ia.REQ : sel == 1 ? ib.REQ : ic.REQ;
    o_ren = sel == 0 ? ia.ELEM_REN : sel == 1 ? ib.ELEM_REN : ic.ELEM_REN;
    o_addr = sel == 0 ? ia.REQ_ADDR : sel == 1 ? ib.REQ_ADDR : ic.REQ_ADDR;
    o_len = sel == 0 ? ia.REQ_LEN : sel == 1 ? ib.REQ_LEN : ic.REQ_LEN;
    o_done = sel == 0 ? done_a : sel == 1 ? done_b : done_c;
    o_busy = sel == 0 ? busy_a : sel == 1 ? busy_b : busy_c;
    o_out = sel == 0 ? int'(da.r_outstanding) : sel == 1 ? int'(db.r_outstanding) : int'(dc.r_outstanding);
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_n++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_en) cons = 3'($urandom_range(0, 4));
    if (inv_en) chk("outstanding_le_fifo", o_out <= 64, 1);
  endtask
  task automatic do_reset();
    rst = 1;
    tick();
    rst = 0;
  endtask
  // Reference split: size cap and 4KB page limit, applied word-wise from the aligned address.
  function automatic void push_split(input logic [63:0] a, input logic [31:0] l, input int cap);
    logic [63:0] x;
    logic [31:0] r;
    int n, bnd;
    x = a & ~64'h3;
    r = l;
    while (r != 0) begin
      bnd = (4096 - int'(x[11:0])) / 4;
      n = (32 << cap) < bnd ? (32 << cap) : bnd;
      if (r < 32'(n)) n = int'(r);
      sbq.push_back('{x, 10'(n)});
      x += 64'(n * 4);
      r -= 32'(n);
    end
  endfunction
  task automatic run_elem(input logic [63:0] a, input logic [31:0] l, input int dmax, output int bud);
    int dly, last;
    logic got;
    ev = 1; ea = a; el = l; bud = 0;
    #1;
    while (!o_ren && bud < 500) begin tick(); bud++; end
    chk("elem_pop", o_ren, 1);
    tick();
    ev = 0;
    bud = 0; dly = -1; last = -1; got = o_done;
    while (!got && bud < 5000) begin
      if (o_req && dly < 0) dly = int'($urandom_range(0, dmax));
      if (o_req && dly == 0) begin
        ack = 1; last = bud; dly = -1;
        chk("sb_has_entry", sbq.size() > 0, 1);
        if (sbq.size() > 0) begin
          chk("req_addr", o_addr, sbq[0].a);
          chk("req_len", 64'(o_len), 64'(sbq[0].l));
          void'(sbq.pop_front());
        end
        chk("no_4k_cross", {52'd0, o_addr[11:0]} + (o_len == 0 ? 64'd4096 : {52'd0, o_len, 2'b00}) <= 64'd4096, 1);
        sum_req += o_len == 0 ? 64'd1024 : 64'(o_len);
      end else if (dly > 0) dly--;
      tick();
      bud++;
      ack = 0;
      got = o_done;
    end
    chk("elem_done", got, 1);
    chk("done_cycle", 64'(bud), 64'(last + 1));
    chk("sb_drained", sbq.size(), 0);
    sum_elem += 64'(l);
  endtask
  initial begin
    logic [63:0] a;
    logic [31:0] l;
    int d;
    tick(); tick();
    chk("rst_req", o_req, 0);
    chk("rst_done", o_done, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_addr", o_addr, 0);
    chk("rst_len", 64'(o_len), 0);
    chk("rst_outstanding", o_out, 0);
    rst = 0;
    sel = 0; cfg = 3'b001;
    sbq.push_back('{64'h1_0000_0F80, 10'd32});
    sbq.push_back('{64'h1_0000_1000, 10'd64});
    sbq.push_back('{64'h1_0000_1100, 10'd4});
    run_elem(64'h1_0000_0F80, 100, 0, d);
    chk("boundary_done_cycle", d, 6);
    tick();
    chk("boundary_done_pulse", o_done, 0);
    do_reset();
    sel = 0; cfg = 3'b101;
    sbq.push_back('{64'h000, 10'd128});
    sbq.push_back('{64'h200, 10'd128});
    sbq.push_back('{64'h400, 10'd44});
    run_elem(64'h0, 300, 1, d);
    do_reset();
    sel = 1; cfg = 3'b101;
    sbq.push_back('{64'h2000_0000, 10'd0});
    sbq.push_back('{64'h2000_1000, 10'd0});
    run_elem(64'h2000_0000, 2048, 2, d);
    do_reset();
    sel = 2; cfg = 3'b000;
    ev = 1; ea = 64'h0; el = 96;
    tick();
    ev = 0;
    tick();
    chk("stall_req1", o_req, 1);
    chk("stall_addr1", o_addr, 64'h0);
    chk("stall_len1", 64'(o_len), 32);
    ack = 1; tick(); ack = 0; tick();
    chk("stall_req2", o_req, 1);
    chk("stall_addr2", o_addr, 64'h80);
    ack = 1; tick(); ack = 0;
    repeat (3) tick();
    chk("stall_hold", o_req, 0);
    chk("stall_out64", o_out, 64);
    cons = 4;
    repeat (7) tick();
    chk("stall_low7", o_req, 0);
    tick();
    cons = 0;
    chk("stall_out32", o_out, 32);
    chk("stall_low8", o_req, 0);
    tick();
    chk("stall_req3", o_req, 1);
    chk("stall_addr3", o_addr, 64'h100);
    chk("stall_len3", 64'(o_len), 32);
    ack = 1; tick(); ack = 0;
    chk("stall_done", o_done, 1);
    do_reset();
    sel = 0; cfg = 3'b010;
    ev = 1; ea = 64'h0; el = 100;
    tick();
    ev = 0;
    tick();
    chk("abort_req", o_req, 1);
    chk("abort_len", 64'(o_len), 100);
    ack = 1; abort = 1; ev = 1;
    tick();
    ack = 0;
    chk("abort_req_drop", o_req, 0);
    chk("abort_idle", o_busy, 0);
    chk("abort_outstanding", o_out, 100);
    chk("abort_no_done", o_done, 0);
    chk("abort_no_ren", o_ren, 0);
    tick();
    chk("abort_no_done2", o_done, 0);
    chk("abort_no_pop", o_busy, 0);
    abort = 0; ev = 0;
    do_reset();
    ev = 1; ea = 64'h0; el = 100;
    tick();
    ev = 0;
    tick();
    chk("rstmid_req", o_req, 1);
    rst = 1;
    tick();
    chk("rstmid_req_drop", o_req, 0);
    rst = 0;
    tick();
    chk("rstmid_no_done", o_done, 0);
    chk("rstmid_idle", o_busy, 0);
    do_reset();
    sel = 0;
    run_elem(64'h1234, 0, 0, d);
    chk("zero_done_next", d, 0);
    do_reset();
    sel = 2; sum_req = 0; sum_elem = 0; rnd_en = 1; inv_en = 1;
    for (int i = 0; i < 1000; i++) begin
      cfg = 3'($urandom_range(0, 1));
      a = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) a[11:0] = 12'hF00 | 12'($urandom_range(0, 255));
      l = $urandom_range(0, 64);
      push_split(a, l, int'(cfg));
      run_elem(a, l, 3, d);
    end
    rnd_en = 0; inv_en = 0; cons = 0;
    chk("sum_len", sum_req, sum_elem);
    $display("%0d/%0d checks passed", pass_n, total);
    $finish;
  end
endmodule
